future_dec_keysched: RTL and testbench
======================================

FUTURE_DEC_KEYSCHED -- requirements
Module: future_dec_keysched

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; NR+1 round keys are emitted (RK_NR down to RK_0).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to load key_in and begin a decryption key sequence.
REQ-005 key_in  input  [0:127]  128-bit master key; bit 0 is MSB.
REQ-006 rk_ready  input  1  consumer accepts the current round key.
REQ-007 rk_out  output  [0:63]  current round key, equal to bits [0:63] of internal state S.
REQ-008 rk_valid  output  1  rk_out and round_idx are valid.
REQ-009 round_idx  output  [3:0]  index r of the round key on rk_out.
REQ-010 busy  output  1  high outside IDLE.
REQ-011 done  output  1  one-cycle pulse after RK_0 is accepted.

Function
REQ-012 Forward schedule: S_0 = key_in; step r (0-based) maps S_r to S_{r+1} by rotate-left (toward bit 0) of 5 bits if r is even, 16 bits if r is odd; RK_r = S_r[0:63].
REQ-013 The block emits keys in reverse order (RK_NR first) for the decryption datapath.
REQ-014 FSM states: IDLE, EMIT, DONE.
REQ-015 IDLE: on start=1, S <= rotl(key_in, TOT), where TOT = (ceil(NR/2)*5 + floor(NR/2)*16) mod 128 (105 for NR=10); round_idx <= NR; go to EMIT.
REQ-016 start is ignored outside IDLE.
REQ-017 EMIT: rk_valid=1; when rk_ready=1 and round_idx>0, S <= rotr(S, 5 if (round_idx-1) even else 16) and round_idx decrements by 1.
REQ-018 EMIT with rk_ready=1 and round_idx=0: go to DONE; S and round_idx hold.
REQ-019 EMIT with rk_ready=0: S, round_idx, rk_out hold; rk_valid remains 1 (no retraction).
REQ-020 DONE: done=1, rk_valid=0 for exactly one cycle, then IDLE.
REQ-021 Latency: first key valid the cycle after start is sampled; with rk_ready held high, one key per cycle, done asserted NR+2 cycles after start.
REQ-022 rk_valid=0 in IDLE and DONE; rk_out holds its last value when rk_valid=0.

Reset
REQ-023 rst=0 asynchronously forces state IDLE, S=0, round_idx=0, rk_valid=0, busy=0, done=0, rk_out=0.
REQ-024 Reset mid-sequence abandons the sequence; no done pulse is produced.
REQ-025 First start is accepted on the first rising edge after rst deasserts.

Structure
REQ-026 Shared package future_pkg holds NR default, rotation constants (5, 16), TOT, and FSM state encoding.
REQ-027 Sub-module future_key_rot: combinational 128-bit rotator with direction and amount select (5, 16, TOT); instantiated once for the load rotation and once for the step rotation.
REQ-028 Control FSM and S register reside in future_dec_keysched; the implementation is 120-400 lines of RTL.

Verification
REQ-029 key_in=2^127 (bit 0 set), start, rk_ready=1 -> rk_out sequence begins 0x0000_0100_0000_0000 (r=10) and ends 0x8000_0000_0000_0000 (r=0); done pulses exactly once.
REQ-030 key_in=1 -> r=10: 0x0000_0200_0000_0000, r=9: 0x0000_0000_0200_0000, r=8: 0x0000_0000_0010_0000, r=0: 0x0000_0000_0000_0000.
REQ-031 Random key; bench model computes forward RK_0..RK_10 -> DUT output equals model in reverse order, round_idx 10..0.
REQ-032 rk_ready toggled randomly with stalls of 1-5 cycles -> rk_out/round_idx stable while stalled; no key skipped or duplicated.
REQ-033 rst pulsed low at round_idx=6 -> outputs zero immediately; next start replays the full sequence from r=10.
REQ-034 start pulsed during EMIT with a different key -> ignored; sequence continues for the original key.

Source files
------------

// File: rtl/future_pkg.sv
// future_pkg: shared constants, FSM encoding and rotation selectors for the decryption key scheduler.
package future_pkg;
    localparam int NR_DEF   = 10;
    localparam int ROT_EVEN = 5;
    localparam int ROT_ODD  = 16;

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    typedef enum logic [1:0] {AMT_EVEN, AMT_ODD, AMT_TOT} amt_t;

    // Net forward rotation after nr steps: even steps rotate by 5, odd steps by 16.
    function automatic int calc_tot(int nr);
        return (((nr + 1) / 2) * ROT_EVEN + (nr / 2) * ROT_ODD) % 128;
    endfunction

    localparam int TOT_DEF = calc_tot(NR_DEF);
endpackage

// File: rtl/future_key_rot.sv
// future_key_rot: combinational 128-bit rotator (bit 0 = MSB).
// Ports: din/dout 128-bit data, dir_right 0=rotate toward bit 0, 1=away; amt selects 5, 16 or TOT.
module future_key_rot
    import future_pkg::*;
#(
    parameter int TOT = TOT_DEF
) (
    input  logic [0:127] din,
    input  logic         dir_right,
    input  amt_t         amt,
    output logic [0:127] dout
);
    logic [6:0] n;
    logic [6:0] n_left;

    always_comb begin
        n = amt == AMT_EVEN ? 7'(ROT_EVEN) : amt == AMT_ODD ? 7'(ROT_ODD) : 7'(TOT);
        // A right rotation by n is a left rotation by 128-n (mod 128).
        n_left = dir_right ? 7'd0 - n : n;
        dout = (din << n_left) | (din >> (8'd128 - {1'b0, n_left}));
    end
endmodule

// File: rtl/future_dec_keysched.sv
// future_dec_keysched: emits round keys RK_NR..RK_0 for decryption with a valid/ready handshake.
// Ports: clk, rst (async active-low), start/key_in load a master key; rk_out/round_idx/rk_valid
// present the current key, rk_ready accepts it; busy high outside IDLE; done pulses after RK_0.
module future_dec_keysched
    import future_pkg::*;
#(
    parameter int NR = NR_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    input  logic         rk_ready,
    output logic [0:63]  rk_out,
    output logic         rk_valid,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);
    localparam int         TOT    = calc_tot(NR);
    localparam logic [3:0] NR_IDX = 4'(NR);

    state_t       state_q, state_d;
    logic [0:127] s_q, s_d, s_load, s_step;
    logic [3:0]   idx_q, idx_d;

    // Jump straight from the master key to the last forward state S_NR.
    future_key_rot #(.TOT(TOT)) u_load (
        .din      (key_in),
        .dir_right(1'b0),
        .amt      (AMT_TOT),
        .dout     (s_load)
    );

    // Undo forward step idx-1: odd idx means idx-1 is even, which used the 5-bit rotation.
    future_key_rot #(.TOT(TOT)) u_step (
        .din      (s_q),
        .dir_right(1'b1),
        .amt      (idx_q[0] ? AMT_EVEN : AMT_ODD),
        .dout     (s_step)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (start) begin
                s_d     = s_load;
                idx_d   = NR_IDX;
                state_d = EMIT;
            end
            EMIT: if (rk_ready) begin
                if (idx_q == 4'd0) state_d = DONE;
                else begin
                    s_d   = s_step;
                    idx_d = idx_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
        end
    end

    assign rk_out    = s_q[0:63];
    assign rk_valid  = state_q == EMIT;
    assign round_idx = idx_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_future_dec_keysched.sv
// tb_future_dec_keysched: directed self-checking bench for future_dec_keysched.
module tb_future_dec_keysched;
    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [0:127] key_in;
    logic         rk_ready;
    logic [0:63]  rk_out;
    logic         rk_valid;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    logic [63:0] hand [0:NR];
    logic [NR:0] hmask;

    future_dec_keysched #(.NR(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_valid (rk_valid),
        .round_idx(round_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [0:127] rotl_m(input logic [0:127] x, input int n);
        logic [0:127] y;
        for (int i = 0; i < 128; i++) y[i] = x[(i + n) % 128];
        return y;
    endfunction

    // Caller is at a negedge; start is raised immediately so the next posedge samples it.
    task automatic run_full(input logic [0:127] key, input bit stall, input bit inject);
        logic [63:0]  ev [0:NR];
        logic [0:127] s;
        int           k;
        s = key;
        for (int r = 0; r <= NR; r++) begin
            ev[r] = s[0:63];
            s = rotl_m(s, (r % 2 == 0) ? 5 : 16);
        end
        start = 1'b1;
        key_in = key;
        rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int r = NR; r >= 0; r--) begin
            k = stall ? int'($urandom_range(1, 5)) : 0;
            rk_ready = 1'b0;
            for (int j = 0; j < k; j++) begin
                chk("stall_rk", rk_out, ev[r]);
                chk("stall_idx", 64'(round_idx), 64'(r));
                chk("stall_valid", 64'(rk_valid), 64'd1);
                @(negedge clk);
            end
            chk("rk", rk_out, ev[r]);
            chk("idx", 64'(round_idx), 64'(r));
            chk("valid", 64'(rk_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("no_early_done", 64'(done), 64'd0);
            if (hmask[r]) chk("hand_rk", rk_out, hand[r]);
            rk_ready = 1'b1;
            if (inject && r == 8) begin
                start = 1'b1;
                key_in = ~key;
            end
            @(negedge clk);
            start = 1'b0;
        end
        rk_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_valid", 64'(rk_valid), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_rk_hold", rk_out, ev[0]);
        @(negedge clk);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid", 64'(rk_valid), 64'd0);
        chk("idle_rk_hold", rk_out, ev[0]);
    endtask

    initial begin
        logic [0:127] rkey;
        rst = 1'b0;
        start = 1'b0;
        rk_ready = 1'b0;
        key_in = '0;
        hmask = '0;
        #2;
        chk("rst_rk", rk_out, 64'd0);
        chk("rst_valid", 64'(rk_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_idx", 64'(round_idx), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Key with only bit 0 set, started on the first edge after reset release.
        hand[NR] = 64'h0000_0100_0000_0000; hmask[NR] = 1'b1;
        hand[0]  = 64'h8000_0000_0000_0000; hmask[0]  = 1'b1;
        run_full({1'b1, 127'd0}, 1'b0, 1'b0);

        // Key = 1.
        hmask = '0;
        hand[10] = 64'h0000_0200_0000_0000; hmask[10] = 1'b1;
        hand[9]  = 64'h0000_0000_0200_0000; hmask[9]  = 1'b1;
        hand[8]  = 64'h0000_0000_0010_0000; hmask[8]  = 1'b1;
        hand[0]  = 64'h0000_0000_0000_0000; hmask[0]  = 1'b1;
        run_full(128'd1, 1'b0, 1'b0);
        hmask = '0;

        rkey = {$urandom, $urandom, $urandom, $urandom};
        run_full(rkey, 1'b0, 1'b0);
        run_full({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);

        // Reset while round_idx = 6, then replay the same key from the top.
        start = 1'b1;
        key_in = rkey;
        @(negedge clk);
        start = 1'b0;
        rk_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_idx", 64'(round_idx), 64'd6);
        rst = 1'b0;
        rk_ready = 1'b0;
        #1;
        chk("mid_rst_rk", rk_out, 64'd0);
        chk("mid_rst_idx", 64'(round_idx), 64'd0);
        chk("mid_rst_valid", 64'(rk_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("held_rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        run_full(rkey, 1'b0, 1'b0);

        // Start with a different key during EMIT is ignored.
        run_full({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
